// File: rtl/ifetch_unit.sv
// Instruction fetch stage: one imem request/ack per instruction, latches word, pc and decoded immediate.
// Optional build macro IFETCH_ALIGN_CHECK_EN: a misaligned pc in IDLE traps to ERR instead of fetching.
module ifetch_unit #(
   parameter int unsigned IMEM_TIMEOUT = 15
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        stall,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   output logic [31:0] immediate,
   output logic        pc_advance,
   output logic        fetch_err
);

   typedef enum logic [2:0] {IDLE, REQ, ADV, HOLD, ERR} state_t;

   state_t     state, state_nx;
   logic [7:0] tmo_cnt;
   logic       drop;
   logic       misalign;
   logic       timeout;
   logic       discard;

`ifdef IFETCH_ALIGN_CHECK_EN
   assign misalign = (pc[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   // An ack on the final allowed REQ cycle wins over the timeout.
   assign timeout    = !imem_ack && (tmo_cnt == 8'(IMEM_TIMEOUT - 1));
   // A flush coinciding with the ack is treated like one seen earlier in REQ.
   assign discard    = drop || flush;
   assign pc_advance = (state == ADV);

   function automatic logic [31:0] decode_imm(input logic [31:0] w);
      logic [31:0] imm;
      imm = '0;
      case (w[6:0])
         7'b0010011, 7'b0000011, 7'b1100111:
            imm = {{20{w[31]}}, w[31:20]};
         7'b0100011:
            imm = {{20{w[31]}}, w[31:25], w[11:7]};
         7'b1100011:
            imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         7'b0110111, 7'b0010111:
            imm = {w[31:12], 12'h000};
         7'b1101111:
            imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
         default:
            imm = '0;
      endcase
      return imm;
   endfunction

   always_ff @(posedge sysclk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = misalign ? ERR : REQ;
         REQ: begin
            if (imem_ack)     state_nx = discard ? IDLE : ADV;
            else if (timeout) state_nx = ERR;
         end
         ADV: begin
            if (flush)      state_nx = IDLE;
            else if (stall) state_nx = HOLD;
            else            state_nx = IDLE;
         end
         HOLD: begin
            if (flush || !stall) state_nx = IDLE;
         end
         ERR:     state_nx = ERR;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         imem_req    <= 1'b0;
         imem_addr   <= '0;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         immediate   <= '0;
         fetch_err   <= 1'b0;
         tmo_cnt     <= '0;
         drop        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (misalign) begin
                  fetch_err <= 1'b1;
               end else begin
                  imem_addr <= pc & 32'hFFFF_FFFC;
                  imem_req  <= 1'b1;
                  tmo_cnt   <= '0;
               end
            end
            REQ: begin
               if (imem_ack) begin
                  imem_req <= 1'b0;
                  if (discard) begin
                     drop <= 1'b0;
                  end else begin
                     instr       <= imem_rdata;
                     instr_pc    <= imem_addr;
                     immediate   <= decode_imm(imem_rdata);
                     instr_valid <= 1'b1;
                  end
               end else begin
                  if (flush) drop <= 1'b1;
                  if (timeout) begin
                     imem_req  <= 1'b0;
                     fetch_err <= 1'b1;
                  end else begin
                     tmo_cnt <= tmo_cnt + 8'd1;
                  end
               end
            end
            ADV, HOLD: begin
               if (flush || !stall) instr_valid <= 1'b0;
            end
            default: begin
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit, built with a 3-cycle imem timeout.
module tb_ifetch_unit;

   logic        sysclk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc = '0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic [31:0] immediate;
   logic        pc_advance;
   logic        fetch_err;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] dec_words [3] = '{32'hFE002C23, 32'h0010006F, 32'hFFFFFFFF};
   logic [31:0] dec_imms  [3] = '{32'hFFFFFFF8, 32'h00000800, 32'h00000000};

   ifetch_unit #(.IMEM_TIMEOUT(3)) dut (
      .sysclk(sysclk), .reset(reset), .pc(pc), .stall(stall), .flush(flush),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .immediate(immediate),
      .pc_advance(pc_advance), .fetch_err(fetch_err)
   );

   always #5 sysclk = ~sysclk;

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; pc = '0;
      tick(); tick();
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b expected 0", imem_req); end
      n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h expected 0", imem_addr); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
      n_cmp++; if (pc_advance !== 1'b0) begin n_err++; $display("FAIL rst_adv: got %b expected 0", pc_advance); end
      n_cmp++; if (fetch_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b expected 0", fetch_err); end
      n_cmp++; if ({instr, instr_pc, immediate} !== 96'h0) begin n_err++; $display("FAIL rst_data: got %h expected 0", {instr, instr_pc, immediate}); end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      tick();
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL basic_req: got %b/%h expected 1/00000000", imem_req, imem_addr); end
      imem_ack = 1'b1; imem_rdata = 32'h00500093;
      tick();
      imem_ack = 1'b0; pc = 32'h4;
      n_cmp++; if (instr_valid !== 1'b1 || pc_advance !== 1'b1) begin n_err++; $display("FAIL basic_valid_adv: got %b%b expected 11", instr_valid, pc_advance); end
      n_cmp++; if (instr !== 32'h00500093) begin n_err++; $display("FAIL basic_instr: got %h expected 00500093", instr); end
      n_cmp++; if (instr_pc !== 32'h0) begin n_err++; $display("FAIL basic_instr_pc: got %h expected 0", instr_pc); end
      n_cmp++; if (immediate !== 32'h5) begin n_err++; $display("FAIL basic_imm: got %h expected 00000005", immediate); end
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL basic_req_drop: got %b expected 0", imem_req); end
      tick();
      n_cmp++; if (pc_advance !== 1'b0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL basic_idle: got adv=%b valid=%b req=%b expected 000", pc_advance, instr_valid, imem_req); end
      tick();
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_err++; $display("FAIL basic_next_req: got %b/%h expected 1/00000004", imem_req, imem_addr); end
   endtask

   task automatic test_back_to_back_stall();
      int valid_cnt;
      int adv_cnt;
      logic prev_adv;
      imem_ack = 1'b1; imem_rdata = 32'hFE000EE3; stall = 1'b1;
      tick();
      imem_ack = 1'b0; pc = 32'h8;
      n_cmp++; if (immediate !== 32'hFFFFFFFC) begin n_err++; $display("FAIL branch_imm: got %h expected fffffffc", immediate); end
      n_cmp++; if (instr_pc !== 32'h4) begin n_err++; $display("FAIL branch_pc: got %h expected 00000004", instr_pc); end
      valid_cnt = int'(instr_valid);
      adv_cnt   = int'(pc_advance);
      prev_adv  = pc_advance;
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (i == 4) begin
            stall = 1'b0;
            n_cmp++; if (instr !== 32'hFE000EE3 || immediate !== 32'hFFFFFFFC) begin n_err++; $display("FAIL hold_frozen: got %h/%h expected fe000ee3/fffffffc", instr, immediate); end
         end
         n_cmp++; if (prev_adv && pc_advance) begin n_err++; $display("FAIL adv_consecutive: got 1 expected 0 at cycle %0d", i); end
         prev_adv  = pc_advance;
         valid_cnt += int'(instr_valid);
         adv_cnt   += int'(pc_advance);
      end
      n_cmp++; if (valid_cnt !== 5) begin n_err++; $display("FAIL hold_valid_cycles: got %0d expected 5", valid_cnt); end
      n_cmp++; if (adv_cnt !== 1) begin n_err++; $display("FAIL hold_adv_pulses: got %0d expected 1", adv_cnt); end
   endtask

   task automatic test_flush_req();
      int bad;
      bad = 0;
      tick();
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_err++; $display("FAIL flush_req_addr: got %b/%h expected 1/00000008", imem_req, imem_addr); end
      flush = 1'b1; pc = 32'h100;
      tick();
      flush = 1'b0;
      bad += int'(instr_valid | pc_advance);
      tick();
      bad += int'(instr_valid | pc_advance);
      n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL flush_addr_stable: got %h expected 00000008", imem_addr); end
      imem_ack = 1'b1; imem_rdata = 32'h00500093;
      tick();
      imem_ack = 1'b0;
      bad += int'(instr_valid | pc_advance);
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL flush_no_deliver: got %0d expected 0", bad); end
      n_cmp++; if (imem_req !== 1'b0 || fetch_err !== 1'b0) begin n_err++; $display("FAIL flush_ack_last_cycle: got req=%b err=%b expected 0 0", imem_req, fetch_err); end
      tick();
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL flush_refetch: got %b/%h expected 1/00000100", imem_req, imem_addr); end
      imem_ack = 1'b1; imem_rdata = 32'h12345037;
      tick();
      imem_ack = 1'b0; pc = 32'h104;
      n_cmp++; if (instr_valid !== 1'b1 || immediate !== 32'h12345000 || instr_pc !== 32'h100) begin n_err++; $display("FAIL flush_after_deliver: got %b/%h/%h expected 1/12345000/00000100", instr_valid, immediate, instr_pc); end
      tick();
   endtask

   task automatic test_decode();
      logic [31:0] cur;
      cur = 32'h104;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (imem_addr !== cur) begin n_err++; $display("FAIL dec_addr%0d: got %h expected %h", i, imem_addr, cur); end
         imem_ack = 1'b1; imem_rdata = dec_words[i];
         tick();
         imem_ack = 1'b0;
         n_cmp++; if (immediate !== dec_imms[i] || instr_valid !== 1'b1) begin n_err++; $display("FAIL dec_imm%0d: got %h valid=%b expected %h valid=1", i, immediate, instr_valid, dec_imms[i]); end
         if (i == 0) begin flush = 1'b1; stall = 1'b1; end
         cur = cur + 32'h4; pc = cur;
         tick();
         n_cmp++; if (instr_valid !== 1'b0 || pc_advance !== 1'b0) begin n_err++; $display("FAIL dec_release%0d: got valid=%b adv=%b expected 0 0", i, instr_valid, pc_advance); end
         flush = 1'b0; stall = 1'b0;
      end
   endtask

   task automatic test_timeout();
      tick(); tick(); tick();
      n_cmp++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin n_err++; $display("FAIL tmo_early: got req=%b err=%b expected 1 0", imem_req, fetch_err); end
      tick();
      n_cmp++; if (imem_req !== 1'b0 || fetch_err !== 1'b1) begin n_err++; $display("FAIL tmo_fire: got req=%b err=%b expected 0 1", imem_req, fetch_err); end
      imem_ack = 1'b1; imem_rdata = 32'h00500093;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc_advance !== 1'b0) begin n_err++; $display("FAIL tmo_sticky%0d: got err=%b req=%b valid=%b adv=%b expected 1000", i, fetch_err, imem_req, instr_valid, pc_advance); end
      end
      imem_ack = 1'b0;
   endtask

   task automatic test_reset_hold();
      reset = 1'b1; pc = 32'h200;
      tick();
      reset = 1'b0;
      n_cmp++; if (fetch_err !== 1'b0) begin n_err++; $display("FAIL reset_clears_err: got %b expected 0", fetch_err); end
      tick();
      imem_ack = 1'b1; imem_rdata = 32'h00500093; stall = 1'b1;
      tick();
      imem_ack = 1'b0;
      tick();
      n_cmp++; if (instr_valid !== 1'b1 || pc_advance !== 1'b0) begin n_err++; $display("FAIL hold_state: got valid=%b adv=%b expected 1 0", instr_valid, pc_advance); end
      reset = 1'b1; pc = 32'h40;
      tick();
      reset = 1'b0; stall = 1'b0;
      n_cmp++; if ({imem_req, instr_valid, pc_advance, fetch_err} !== 4'b0 || {imem_addr, instr, instr_pc, immediate} !== 128'h0) begin n_err++; $display("FAIL reset_in_hold: got %b/%h expected all zero", {imem_req, instr_valid, pc_advance, fetch_err}, {imem_addr, instr, instr_pc, immediate}); end
      tick();
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_err++; $display("FAIL reset_refetch: got %b/%h expected 1/00000040", imem_req, imem_addr); end
   endtask

   task automatic test_align();
      reset = 1'b1;
      tick();
`ifdef IFETCH_ALIGN_CHECK_EN
      pc = 32'h6; reset = 1'b0;
      tick();
      n_cmp++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin n_err++; $display("FAIL align_trap: got err=%b req=%b expected 1 0", fetch_err, imem_req); end
      tick(); tick();
      n_cmp++; if (imem_req !== 1'b0 || fetch_err !== 1'b1) begin n_err++; $display("FAIL align_no_req: got req=%b err=%b expected 0 1", imem_req, fetch_err); end
`else
      pc = 32'h46; reset = 1'b0;
      tick();
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h44 || fetch_err !== 1'b0) begin n_err++; $display("FAIL align_ignored: got req=%b addr=%h err=%b expected 1 00000044 0", imem_req, imem_addr, fetch_err); end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_back_to_back_stall();
      test_flush_req();
      test_decode();
      test_timeout();
      test_reset_hold();
      test_align();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
